madd_pipe: RTL and testbench

Parametrised, pipelined multiply-add unit. It computes a*b+c on W-bit unsigned operands and adds a multiply-accumulate mode with saturation. It is the sequential successor of the fixed 3-bit combinational madd circuits used by the error-evaluation flow. It sits between the stimulus streamer and the error comparator, behind valid/ready handshakes on both sides, and is the exact (golden) datapath that approximate variants are scored against.

---
 rtl/madd_pkg.sv | 13 +
 rtl/madd_sat_acc.sv | 56 +++++
 rtl/madd_pipe.sv | 136 +++++++++++++
 tb/tb_madd_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/madd_pkg.sv
// Shared constants and the exact multiply-add reference for the madd datapath family.
package madd_pkg;

  localparam logic MADD_SINGLE = 1'b0;
  localparam logic MADD_MAC    = 1'b1;

  // Exact a*b+c, wide enough for any operand width up to 32 bits; callers truncate to 2W bits.
  function automatic logic [63:0] madd_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return ({32'd0, a} * {32'd0, b}) + {32'd0, c};
  endfunction

endpackage

// File: rtl/madd_sat_acc.sv
// Saturating accumulator with sticky overflow; clears itself after the closing beat of a group.
module madd_sat_acc #(
  parameter int unsigned IN_W  = 6,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             last_i,
  input  logic [IN_W-1:0]  s_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  localparam int unsigned SumW = ACC_W + 1;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [SumW-1:0]  raw_sum;
  logic             new_ovf;

  // Saturated running total including the current beat; valid whenever the caller looks at it.
  always_comb begin
    raw_sum = {1'b0, acc_q} + SumW'(s_i);
    new_ovf = raw_sum[ACC_W];
    sum_o   = new_ovf ? '1 : raw_sum[ACC_W-1:0];
    ovf_o   = ovf_q | new_ovf;
  end

  // Fold the beat in, or clear for the next group once the closing beat has been consumed.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (en_i) begin
      if (last_i) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_o;
        ovf_d = ovf_o;
      end
    end
  end

  // Accumulator state, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/madd_pipe.sv
// Two-stage elastic multiply-add / saturating MAC unit with valid/ready on both sides.
module madd_pipe
  import madd_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned ACC_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     in_a_i,
  input  logic [W-1:0]     in_b_i,
  input  logic [W-1:0]     in_c_i,
  input  logic             in_mode_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             out_ovf_o
);

  localparam int unsigned PW = 2 * W;

  if (ACC_W < 2 * W) begin : gen_acc_w_check
    $error("madd_pipe: ACC_W must be at least 2*W");
  end

  logic             s1_valid_q, s1_valid_d;
  logic [PW-1:0]    s1_p_q, s1_p_d;
  logic [W-1:0]     s1_c_q, s1_c_d;
  logic             s1_mode_q, s1_mode_d;
  logic             s1_last_q, s1_last_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic             in_accept;
  logic             s1_emits;
  logic             s2_adv;
  logic             acc_en;
  logic [PW-1:0]    s2_sum;
  logic [ACC_W-1:0] acc_sum;
  logic             acc_ovf;

  // Handshake: a non-emitting MAC beat in stage 1 can always retire, even behind a stalled output.
  always_comb begin
    s1_emits   = (s1_mode_q == MADD_SINGLE) || s1_last_q;
    s2_adv     = s1_valid_q && (!out_valid_q || out_ready_i || !s1_emits);
    in_ready_o = !rst_i && (!s1_valid_q || s2_adv);
    in_accept  = in_valid_i && in_ready_o;
    acc_en     = s2_adv && (s1_mode_q == MADD_MAC);
  end

  // Stage 1 next state: capture the product and side-band on accept.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_p_d     = s1_p_q;
    s1_c_d     = s1_c_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_p_d     = PW'(in_a_i) * PW'(in_b_i);
      s1_c_d     = in_c_i;
      s1_mode_d  = in_mode_i;
      s1_last_d  = in_last_i;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  assign s2_sum = s1_p_q + PW'(s1_c_q);

  madd_sat_acc #(
    .IN_W  (PW),
    .ACC_W (ACC_W)
  ) u_sat_acc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (acc_en),
    .last_i (s1_last_q),
    .s_i    (s2_sum),
    .sum_o  (acc_sum),
    .ovf_o  (acc_ovf)
  );

  // Output register next state: load on an emitting advance, hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (s2_adv && s1_emits) begin
      out_valid_d = 1'b1;
      if (s1_mode_q == MADD_SINGLE) begin
        out_data_d = ACC_W'(s2_sum);
        out_ovf_d  = 1'b0;
      end else begin
        out_data_d = acc_sum;
        out_ovf_d  = acc_ovf;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_p_q      <= '0;
      s1_c_q      <= '0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_p_q      <= s1_p_d;
      s1_c_q      <= s1_c_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Hide a pending result during reset so consumers never take a beat that is being discarded.
  assign out_valid_o = out_valid_q && !rst_i;
  assign out_data_o  = out_data_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_madd_pipe.sv
// Self-checking bench for madd_pipe: directed scenarios plus randomized traffic vs a queue model.
module tb_madd_pipe;
  import madd_pkg::madd_ref;

  localparam int unsigned W     = 3;
  localparam int unsigned ACC_W = 12;
  localparam int          SAT   = 4095;

  logic             clk;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [W-1:0]     in_a_i, in_b_i, in_c_i;
  logic             in_mode_i, in_last_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [ACC_W-1:0] out_data_o;
  logic             out_ovf_o;

  madd_pipe #(
    .W     (W),
    .ACC_W (ACC_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_a_i      (in_a_i),
    .in_b_i      (in_b_i),
    .in_c_i      (in_c_i),
    .in_mode_i   (in_mode_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ovf_o   (out_ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected results in acceptance order: {ovf, data}.
  logic [12:0] exp_q[$];
  int          m_acc = 0;
  bit          m_ovf = 1'b0;
  int          last_data = -1;
  int          last_ovf  = -1;
  bit          stall_seen = 1'b0;
  logic [12:0] stall_val  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Reference behaviour: plain integer arithmetic on the group total.
  function automatic void model_accept(input int a, input int b, input int c, input bit mode,
                                       input bit last);
    int s;
    int sum;
    bit n;
    s = a * b + c;
    if (!mode) begin
      exp_q.push_back({1'b0, 12'(s)});
    end else begin
      sum = m_acc + s;
      n   = 1'b0;
      if (sum > SAT) begin
        sum = SAT;
        n   = 1'b1;
      end
      if (last) begin
        exp_q.push_back({m_ovf | n, 12'(sum)});
        m_acc = 0;
        m_ovf = 1'b0;
      end else begin
        m_acc = sum;
        m_ovf = m_ovf | n;
      end
    end
  endfunction

  // One clock cycle: drive at negedge, sample 1 time unit later, score, leave edge to come.
  task automatic tick(input bit v, input int a, input int b, input int c, input bit mode,
                      input bit last, input bit ordy, input bit rst, output bit acc);
    logic [12:0] e;
    @(negedge clk);
    rst_i       = rst;
    in_valid_i  = v;
    in_a_i      = a[2:0];
    in_b_i      = b[2:0];
    in_c_i      = c[2:0];
    in_mode_i   = mode;
    in_last_i   = last;
    out_ready_i = ordy;
    #1;
    acc = in_valid_i && in_ready_o;
    if (stall_seen && out_valid_o)
      check("stall_stable", 32'({out_ovf_o, out_data_o}), 32'(stall_val));
    stall_seen = out_valid_o && !out_ready_i;
    stall_val  = {out_ovf_o, out_data_o};
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_data_o), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data_o), 32'(e[11:0]));
        check("out_ovf", 32'(out_ovf_o), 32'(e[12]));
      end
      last_data = int'(out_data_o);
      last_ovf  = int'(out_ovf_o);
    end
    if (acc) model_accept(a & 7, b & 7, c & 7, mode, last);
    if (rst) begin
      exp_q.delete();
      m_acc      = 0;
      m_ovf      = 1'b0;
      stall_seen = 1'b0;
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, ordy, 1'b0, acc);
  endtask

  task automatic send(input int a, input int b, input int c, input bit mode, input bit last,
                      input bit ordy);
    bit acc;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) tick(1'b1, a, b, c, mode, last, ordy, 1'b0, acc);
    if (!acc) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid_o) && k < 40) begin
      idle(1'b1);
      k++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    bit acc;
    int idx;
    rst_i = 1'b1; in_valid_i = 1'b0; in_a_i = '0; in_b_i = '0; in_c_i = '0;
    in_mode_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b0;

    // Reset state
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    tick(1'b1, 1, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    check("rst_in_ready", 32'(in_ready_o), 32'(0));
    check("rst_out_valid", 32'(out_valid_o), 32'(0));
    idle(1'b1);
    check("post_rst_in_ready", 32'(in_ready_o), 32'(1));
    check("post_rst_out_valid", 32'(out_valid_o), 32'(0));
    check("post_rst_data", 32'(out_data_o), 32'(0));
    check("post_rst_ovf", 32'(out_ovf_o), 32'(0));

    // Single madd latency: result visible two cycles after the accepting cycle
    tick(1'b1, 5, 6, 7, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("lat_accept", 32'(acc), 32'(1));
    idle(1'b1);
    check("lat_cyc1_valid", 32'(out_valid_o), 32'(0));
    idle(1'b1);
    check("lat_cyc2_valid", 32'(out_valid_o), 32'(1));
    check("lat_data", 32'(out_data_o), 32'(37));
    check("lat_ovf", 32'(out_ovf_o), 32'(0));
    drain();

    // Corner operands
    send(7, 7, 7, 1'b0, 1'b0, 1'b1); drain();
    check("corner_777", 32'(last_data), 32'(56));
    send(0, 0, 0, 1'b0, 1'b0, 1'b1); drain();
    check("corner_000", 32'(last_data), 32'(0));
    send(0, 7, 7, 1'b0, 1'b0, 1'b1); drain();
    check("corner_077", 32'(last_data), 32'(7));

    // Full operand sweep, also cross-checking the shared reference function
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 8; c++) begin
          check("madd_ref", 32'(madd_ref(32'(a), 32'(b), 32'(c))), 32'(a * b + c));
          send(a, b, c, 1'b0, 1'b0, 1'b1);
        end
    drain();

    // Backpressure: only two beats fit while the consumer stalls
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      tick(idx < 4, idx + 1, 2, idx, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepts", 32'(idx), 32'(2));
    check("bp_in_ready_low", 32'(in_ready_o), 32'(0));
    check("bp_out_valid", 32'(out_valid_o), 32'(1));
    check("bp_head_data", 32'(out_data_o), 32'(2));
    while (idx < 4) begin
      send(idx + 1, 2, idx, 1'b0, 1'b0, 1'b1);
      idx++;
    end
    drain();
    check("bp_last_data", 32'(last_data), 32'(11));

    // MAC group with an interleaved single madd
    send(3, 4, 1, 1'b1, 1'b0, 1'b1);
    send(1, 1, 1, 1'b0, 1'b0, 1'b1);
    drain();
    check("mac_passthru", 32'(last_data), 32'(2));
    send(2, 2, 0, 1'b1, 1'b0, 1'b1);
    send(7, 7, 7, 1'b1, 1'b1, 1'b1);
    drain();
    check("mac_total", 32'(last_data), 32'(73));
    check("mac_ovf", 32'(last_ovf), 32'(0));

    // Saturation: 74 * 56 = 4144 exceeds 4095
    for (int k = 0; k < 74; k++) send(7, 7, 7, 1'b1, k == 73, 1'b1);
    drain();
    check("sat_data", 32'(last_data), 32'(SAT));
    check("sat_ovf", 32'(last_ovf), 32'(1));
    send(1, 1, 1, 1'b1, 1'b1, 1'b1);
    drain();
    check("post_sat_data", 32'(last_data), 32'(2));
    check("post_sat_ovf", 32'(last_ovf), 32'(0));

    // Reset mid-group while a result is stalled
    send(1, 2, 3, 1'b0, 1'b0, 1'b0);
    send(2, 2, 2, 1'b1, 1'b0, 1'b0);
    send(3, 3, 3, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    check("midrst_in_ready", 32'(in_ready_o), 32'(0));
    check("midrst_out_valid", 32'(out_valid_o), 32'(0));
    idle(1'b1);
    check("midrst_discard", 32'(out_valid_o), 32'(0));
    send(2, 3, 0, 1'b1, 1'b1, 1'b1);
    drain();
    check("midrst_group", 32'(last_data), 32'(6));
    check("midrst_ovf", 32'(last_ovf), 32'(0));

    // Randomized traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, 1'b0, acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
